reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: WE  in  1  allocate a new entry at the tail.
REQ-004 SHALL have ports: RE  in  1  retire (commit) the head entry.
REQ-005 SHALL have ports: flush  in  1  discard all entries.
REQ-006 SHALL have ports: inst  in  lc3b_opcode  opcode written into the allocated entry.
REQ-007 SHALL have ports: dest  in  lc3b_reg (3)  destination register written into the allocated entry.
REQ-008 SHALL have ports: value  in  16  initial value written into the allocated entry.
REQ-009 SHALL have ports: predict  in  1  branch-prediction bit written into the allocated entry.
REQ-010 SHALL have ports: addr  in  3  reserved in this revision; ignored by the logic; tie to 0.
REQ-011 SHALL have ports: CDB_in  in  CDB struct (data 16, valid 1, tag 3)  result broadcast.
REQ-012 SHALL have ports: addr_out  out  3  tail index, i.e. the tag the next WE will allocate.
REQ-013 SHALL have ports: valid_out  out  1  head entry occupied and ready to commit.
REQ-014 SHALL have ports: inst_out, dest_out, predict_out  out  lc3b_opcode/3/1  head entry fields.
REQ-015 SHALL have ports: value_out  out  16  head entry value.
REQ-016 SHALL have ports: full_out  out  1  all 8 entries occupied.

Function
REQ-017 SHALL hold 8 entries, each with busy, ready, inst, dest, value[15:0] and predict; circular head/tail pointers (3 bits) and a count 0..8.
REQ-018 SHALL drive all outputs combinationally from registered state; inputs affect outputs only after the next rising edge.
REQ-019 WE with count<8 SHALL write inst/dest/value/predict into entry[tail], set busy=1 and ready=0, and advance tail mod 8.
REQ-020 WE with count==8 SHALL be ignored with no state change.
REQ-021 RE with valid_out==1 SHALL clear busy and ready of entry[head] and advance head mod 8.
REQ-022 RE with valid_out==0 (empty or head not ready) SHALL be ignored.
REQ-023 CDB_in.valid==1 with entry[CDB_in.tag] busy SHALL write CDB_in.data into that entry's value and set ready=1.
REQ-024 A CDB broadcast to a non-busy entry SHALL be ignored.
REQ-025 WE and RE in the same cycle SHALL both take effect when individually legal; fullness is judged on the pre-edge count, so a full ROB does not accept WE even if RE retires in that cycle.
REQ-026 A CDB broadcast to the head entry in the same cycle as RE SHALL not allow that commit; valid_out rises the following cycle.
REQ-027 A CDB broadcast to entry[tail] in the same cycle as WE SHALL be lost, because allocation overrides it.
REQ-028 flush SHALL clear busy/ready of all entries, set head=tail=count=0, and override WE, RE and CDB in that cycle.
REQ-029 Pointer wrap SHALL be 7->0 for both head and tail.
REQ-030 full_out SHALL be 1 iff count==8.
REQ-031 When valid_out==0 the head field outputs SHALL still show entry[head] contents; consumers qualify them with valid_out.

Reset
REQ-032 rst==1 at a rising edge SHALL produce the same result as flush and take priority over every other input.
REQ-033 After reset, entry field contents SHALL be zeroed, and outputs SHALL be: addr_out=0, valid_out=0, full_out=0, value_out=0, dest_out=0, predict_out=0, inst_out=op_add (encoding 0).
REQ-034 rst asserted mid-operation SHALL discard all in-flight entries within that cycle.

Verification
REQ-035 Reset, then WE once with inst=op_add, dest=3, value=0x1234 -> addr_out=1, valid_out=0, full_out=0.
REQ-036 Continuing REQ-035, drive CDB tag=0, data=0xBEEF, valid=1 -> next cycle valid_out=1, value_out=0xBEEF, dest_out=3; RE -> valid_out=0.
REQ-037 Eight consecutive WE -> full_out=1 and addr_out=0; a ninth WE is ignored; RE on a ready head plus WE in the same cycle -> only RE takes effect.
REQ-038 CDB to tag 2 while the head (tag 0) is not ready -> valid_out stays 0; RE has no effect.
REQ-039 Fill 5 entries, assert flush -> next cycle addr_out=0, full_out=0, valid_out=0; subsequent WE allocates tag 0.
REQ-040 Retire and allocate past index 7 -> head and tail wrap to 0, and data and order are preserved.

Source files
------------

// File: rtl/reorder_buffer.sv
// Eight-entry circular reorder buffer: in-order allocate at the tail, CDB result
// writeback by tag, in-order commit from the head. Outputs come from registered state only.
package lc3b_types;
  typedef enum logic [3:0] {
    op_add = 4'd0, op_and = 4'd1, op_br = 4'd2, op_jmp = 4'd3,
    op_jsr = 4'd4, op_ldb = 4'd5, op_ldi = 4'd6, op_ldr = 4'd7,
    op_lea = 4'd8, op_not = 4'd9, op_rti = 4'd10, op_shf = 4'd11,
    op_stb = 4'd12, op_sti = 4'd13, op_str = 4'd14, op_trap = 4'd15
  } lc3b_opcode;

  typedef logic [2:0] lc3b_reg;

  typedef struct packed {
    logic [15:0] data;
    logic        valid;
    logic [2:0]  tag;
  } cdb_t;
endpackage

module reorder_buffer
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic        RE,
  input  logic        flush,
  input  lc3b_opcode  inst,
  input  lc3b_reg     dest,
  input  logic [15:0] value,
  input  logic        predict,
  input  logic [2:0]  addr,
  input  cdb_t        CDB_in,
  output logic [2:0]  addr_out,
  output logic        valid_out,
  output lc3b_opcode  inst_out,
  output lc3b_reg     dest_out,
  output logic        predict_out,
  output logic [15:0] value_out,
  output logic        full_out
);

  lc3b_opcode  inst_q  [8];
  lc3b_reg     dest_q  [8];
  logic [15:0] value_q [8];
  logic [7:0]  busy_q;
  logic [7:0]  ready_q;
  logic [7:0]  predict_q;
  logic [2:0]  head_q;
  logic [2:0]  tail_q;
  logic [3:0]  count_q;

  logic do_we;
  logic do_re;
  logic unused_addr;

  assign unused_addr = ^addr;

  assign valid_out   = busy_q[head_q] & ready_q[head_q];
  assign full_out    = (count_q == 4'd8);
  assign addr_out    = tail_q;
  assign inst_out    = inst_q[head_q];
  assign dest_out    = dest_q[head_q];
  assign value_out   = value_q[head_q];
  assign predict_out = predict_q[head_q];

  // Legality is judged on pre-edge state, so a full buffer refuses WE even while retiring.
  assign do_we = WE && !full_out;
  assign do_re = RE && valid_out;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= 3'd0;
      tail_q  <= 3'd0;
      count_q <= 4'd0;
      busy_q  <= 8'd0;
      ready_q <= 8'd0;
      if (rst) begin
        predict_q <= 8'd0;
        for (int i = 0; i < 8; i++) begin
          inst_q[i]  <= op_add;
          dest_q[i]  <= 3'd0;
          value_q[i] <= 16'd0;
        end
      end
    end else begin
      if (CDB_in.valid && busy_q[CDB_in.tag]) begin
        value_q[CDB_in.tag] <= CDB_in.data;
        ready_q[CDB_in.tag] <= 1'b1;
      end
      // Allocation comes after the CDB write so it wins on a same-entry collision.
      if (do_we) begin
        inst_q[tail_q]    <= inst;
        dest_q[tail_q]    <= dest;
        value_q[tail_q]   <= value;
        predict_q[tail_q] <= predict;
        busy_q[tail_q]    <= 1'b1;
        ready_q[tail_q]   <= 1'b0;
        tail_q            <= tail_q + 3'd1;
      end
      if (do_re) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= head_q + 3'd1;
      end
      count_q <= count_q + {3'd0, do_we} - {3'd0, do_re};
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based model of in-flight instructions
// checked every cycle, plus hand-computed literal expectations along the way.
module tb_reorder_buffer;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        rst, WE, RE, flush, predict;
  lc3b_opcode  inst;
  lc3b_reg     dest;
  logic [15:0] value;
  logic [2:0]  addr;
  cdb_t        CDB_in;
  logic [2:0]  addr_out;
  logic        valid_out, predict_out, full_out;
  lc3b_opcode  inst_out;
  lc3b_reg     dest_out;
  logic [15:0] value_out;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .WE(WE), .RE(RE), .flush(flush),
    .inst(inst), .dest(dest), .value(value), .predict(predict), .addr(addr),
    .CDB_in(CDB_in), .addr_out(addr_out), .valid_out(valid_out),
    .inst_out(inst_out), .dest_out(dest_out), .predict_out(predict_out),
    .value_out(value_out), .full_out(full_out)
  );

  // Model: program-ordered queue of in-flight instructions, each tagged with its slot.
  typedef struct {
    logic [2:0]  tag;
    lc3b_opcode  inst;
    lc3b_reg     dest;
    logic [15:0] value;
    logic        pred;
    logic        rdy;
  } ent_t;

  ent_t mq[$];
  int   m_tail = 0;
  int   m_n;
  bit   m_hv;
  ent_t m_new;

  always @(posedge clk) begin
    if (rst || flush) begin
      mq.delete();
      m_tail = 0;
    end else begin
      m_n  = mq.size();
      m_hv = (m_n > 0) && mq[0].rdy;
      if (CDB_in.valid)
        foreach (mq[k])
          if (mq[k].tag == CDB_in.tag) begin
            mq[k].value = CDB_in.data;
            mq[k].rdy   = 1'b1;
          end
      if (RE && m_hv) void'(mq.pop_front());
      if (WE && m_n < 8) begin
        m_new.tag   = 3'(m_tail);
        m_new.inst  = inst;
        m_new.dest  = dest;
        m_new.value = value;
        m_new.pred  = predict;
        m_new.rdy   = 1'b0;
        mq.push_back(m_new);
        m_tail = (m_tail + 1) % 8;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_addr", 32'(addr_out), 32'(m_tail));
      check("m_full", 32'(full_out), 32'(mq.size() == 8));
      check("m_valid", 32'(valid_out), 32'(mq.size() > 0 && mq[0].rdy));
      if (mq.size() > 0) begin
        check("m_inst", 32'(inst_out), 32'(mq[0].inst));
        check("m_dest", 32'(dest_out), 32'(mq[0].dest));
        check("m_value", 32'(value_out), 32'(mq[0].value));
        check("m_pred", 32'(predict_out), 32'(mq[0].pred));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0; WE = 1'b0; RE = 1'b0; flush = 1'b0; CDB_in.valid = 1'b0;
  endtask

  task automatic alloc(input lc3b_opcode op, input lc3b_reg d, input logic [15:0] v, input logic p);
    WE = 1'b1; inst = op; dest = d; value = v; predict = p;
  endtask

  task automatic bcast(input logic [2:0] tag, input logic [15:0] data);
    CDB_in.valid = 1'b1; CDB_in.tag = tag; CDB_in.data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; WE = 1'b0; RE = 1'b0; flush = 1'b0; predict = 1'b0;
    inst = op_add; dest = 3'd0; value = 16'd0; addr = 3'd0;
    CDB_in = '0;
    @(negedge clk); #1;
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    chk_en = 1'b1;
    check("rst_addr", 32'(addr_out), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_full", 32'(full_out), 0);
    check("rst_value", 32'(value_out), 0);
    check("rst_dest", 32'(dest_out), 0);
    check("rst_pred", 32'(predict_out), 0);
    check("rst_inst", 32'(inst_out), 0);

    alloc(op_add, 3'd3, 16'h1234, 1'b0); tick();
    check("we1_addr", 32'(addr_out), 1);
    check("we1_valid", 32'(valid_out), 0);
    check("we1_full", 32'(full_out), 0);
    bcast(3'd0, 16'hBEEF); tick();
    check("cdb_valid", 32'(valid_out), 1);
    check("cdb_value", 32'(value_out), 32'h0000BEEF);
    check("cdb_dest", 32'(dest_out), 3);
    RE = 1'b1; tick();
    check("re_valid", 32'(valid_out), 0);

    flush = 1'b1; tick();
    check("flush_addr", 32'(addr_out), 0);
    for (int i = 0; i < 8; i++) begin
      alloc(lc3b_opcode'(4'(i + 1)), 3'(i), 16'h0100 + 16'(i), 1'(i)); tick();
    end
    check("fill_full", 32'(full_out), 1);
    check("fill_addr", 32'(addr_out), 0);
    alloc(op_trap, 3'd7, 16'hFFFF, 1'b1); tick();
    check("ninth_full", 32'(full_out), 1);
    check("ninth_addr", 32'(addr_out), 0);
    bcast(3'd0, 16'hA000); tick();
    check("head0_valid", 32'(valid_out), 1);
    check("head0_value", 32'(value_out), 32'h0000A000);
    RE = 1'b1; alloc(op_not, 3'd1, 16'h0999, 1'b0); tick();
    check("rewe_full", 32'(full_out), 0);
    check("rewe_addr", 32'(addr_out), 0);
    check("rewe_value", 32'(value_out), 32'h00000101);
    check("rewe_valid", 32'(valid_out), 0);

    bcast(3'd2, 16'hC002); tick();
    check("cdb2_valid", 32'(valid_out), 0);
    RE = 1'b1; tick();
    check("re_blocked", 32'(value_out), 32'h00000101);
    bcast(3'd1, 16'hC001); RE = 1'b1; tick();
    check("cdb_re_valid", 32'(valid_out), 1);
    check("cdb_re_value", 32'(value_out), 32'h0000C001);
    RE = 1'b1; tick();
    check("head2_value", 32'(value_out), 32'h0000C002);
    RE = 1'b1; tick();
    check("head3_valid", 32'(valid_out), 0);
    check("head3_value", 32'(value_out), 32'h00000103);

    alloc(op_lea, 3'd5, 16'h0E00, 1'b1); bcast(3'd0, 16'hDEAD); tick();
    check("wecdb_addr", 32'(addr_out), 1);
    for (int t = 3; t < 8; t++) begin
      bcast(3'(t), 16'hD000 + 16'(t)); tick();
      RE = 1'b1; tick();
    end
    check("wrap_valid", 32'(valid_out), 0);
    check("wrap_value", 32'(value_out), 32'h00000E00);
    check("wrap_dest", 32'(dest_out), 5);
    bcast(3'd0, 16'h0E01); RE = 1'b1; tick();
    check("wrap_ready", 32'(value_out), 32'h00000E01);
    RE = 1'b1; tick();
    check("drain_valid", 32'(valid_out), 0);

    for (int i = 0; i < 14; i++) begin
      alloc(lc3b_opcode'(4'(i)), 3'(i), 16'h2000 + 16'(i), 1'(i >> 1));
      if (i > 0) bcast(3'(i), 16'h2100 + 16'(i));
      RE = (i % 3 != 0);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      bcast(3'(k), 16'h3000 + 16'(k)); RE = 1'b1; tick();
    end
    bcast(3'd4, 16'h5555); tick();

    flush = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      alloc(op_str, 3'(i), 16'h6000 + 16'(i), 1'b0); tick();
    end
    check("five_addr", 32'(addr_out), 5);
    flush = 1'b1; alloc(op_sti, 3'd6, 16'h6666, 1'b1); tick();
    check("fl_addr", 32'(addr_out), 0);
    check("fl_full", 32'(full_out), 0);
    check("fl_valid", 32'(valid_out), 0);
    alloc(op_jmp, 3'd2, 16'h7000, 1'b1); tick();
    check("post_fl_addr", 32'(addr_out), 1);
    bcast(3'd0, 16'h7777); tick();
    check("post_fl_valid", 32'(valid_out), 1);
    check("post_fl_value", 32'(value_out), 32'h00007777);
    check("post_fl_pred", 32'(predict_out), 1);

    alloc(op_and, 3'd4, 16'h8001, 1'b1); tick();
    alloc(op_br, 3'd5, 16'h8002, 1'b0); tick();
    rst = 1'b1; alloc(op_shf, 3'd7, 16'h8003, 1'b1); bcast(3'd1, 16'h8888); RE = 1'b1; tick();
    check("mid_rst_addr", 32'(addr_out), 0);
    check("mid_rst_valid", 32'(valid_out), 0);
    check("mid_rst_value", 32'(value_out), 0);
    check("mid_rst_inst", 32'(inst_out), 0);
    check("mid_rst_pred", 32'(predict_out), 0);

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
